serial_paralelo: RTL and testbench



---
 rtl/serial_paralelo.sv | 85 ++++++++
 tb/tb_serial_paralelo.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_paralelo.sv
// serial_paralelo: MSB-first serial-to-byte deserializer with comma (8'hBC) alignment and lock.
// Ports:
//   clk_32f    bit clock, one serial bit sampled per rising edge
//   reset_L    asynchronous active-low reset
//   data_in    serial data, MSB of each byte first
//   data_out   last received non-comma byte
//   valid_out  one-cycle strobe when data_out takes a new byte
//   active     high while locked
//   comma_det  one-cycle pulse on each byte-aligned comma in ALIGN/ACTIVE
`timescale 1ns/1ps
module serial_paralelo #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         BC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       comma_det
);
    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
    state_t     state, state_n;
    logic [7:0] shift_reg, byte_next, data_out_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [3:0] bc_cnt, bc_cnt_n;
    logic       valid_n, comma_n, is_comma, byte_done;
    assign byte_next = {shift_reg[6:0], data_in};
    assign is_comma  = byte_next == COMMA;
    assign byte_done = bit_cnt == 3'd7;
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= SEARCH;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            bc_cnt    <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            comma_det <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= byte_next;
            bit_cnt   <= bit_cnt_n;
            bc_cnt    <= bc_cnt_n;
            data_out  <= data_out_n;
            valid_out <= valid_n;
            comma_det <= comma_n;
            active    <= state_n == ACTIVE;
        end
    end
    always_comb begin
        state_n    = state;
        bit_cnt_n  = (state == SEARCH) ? bit_cnt : bit_cnt + 3'd1;
        bc_cnt_n   = bc_cnt;
        data_out_n = data_out;
        valid_n    = 1'b0;
        comma_n    = 1'b0;
        case (state)
            SEARCH: if (is_comma) begin
                // Sliding-window hit: the next bit starts a byte, so restart the bit counter.
                bit_cnt_n = 3'd0;
                bc_cnt_n  = 4'd1;
                state_n   = (BC_COUNT == 1) ? ACTIVE : ALIGN;
            end
            ALIGN: if (byte_done) begin
                if (is_comma) begin
                    comma_n  = 1'b1;
                    bc_cnt_n = bc_cnt + 4'd1;
                    state_n  = (bc_cnt + 4'd1 == 4'(BC_COUNT)) ? ACTIVE : ALIGN;
                end else begin
                    bc_cnt_n = 4'd0;
                    state_n  = SEARCH;
                end
            end
            ACTIVE: if (byte_done) begin
                comma_n    = is_comma;
                valid_n    = !is_comma;
                data_out_n = is_comma ? data_out : byte_next;
            end
            default: state_n = SEARCH;
        endcase
    end
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: table-driven check of serial_paralelo lock, data capture and reset.
`timescale 1ns/1ps
module tb_serial_paralelo;
    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b1;
    logic       d4 = 1'b0, d1 = 1'b0;
    logic [7:0] data_out4, data_out1;
    logic       valid4, active4, comma4, valid1, active1, comma1;
    int         vectors = 0, miscompares = 0;
    int         cyc = 0, overlaps = 0;
    int         vtimes[$];

    typedef struct {
        logic       rst;
        int         pre_n;
        logic [7:0] pre;
        logic [7:0] din;
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       a;
    } vec_t;
    vec_t tbl[$];

    always #5 clk_32f = ~clk_32f;

    serial_paralelo #(.BC_COUNT(4)) dut4 (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(d4),
        .data_out(data_out4), .valid_out(valid4), .active(active4), .comma_det(comma4)
    );
    serial_paralelo #(.BC_COUNT(1)) dut1 (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(d1),
        .data_out(data_out1), .valid_out(valid1), .active(active1), .comma_det(comma1)
    );

    always @(negedge clk_32f) begin
        cyc <= cyc + 1;
        if (valid4) vtimes.push_back(cyc);
        if (valid4 && comma4) overlaps <= overlaps + 1;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit lane1);
        @(negedge clk_32f);
        if (lane1) d1 = b; else d4 = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lane1);
        for (int i = 7; i >= 0; i--) send_bit(b[i], lane1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_32f);
        #2 reset_L = 1'b0;
        #1;
        chk({tag, " rst data_out"}, data_out4, 8'h00);
        chk({tag, " rst valid"}, {7'd0, valid4}, 8'h00);
        chk({tag, " rst active"}, {7'd0, active4}, 8'h00);
        chk({tag, " rst comma"}, {7'd0, comma4}, 8'h00);
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    task automatic add(input logic rst, input int pre_n, input logic [7:0] pre, input logic [7:0] din,
                       input logic v, input logic [7:0] d, input logic c, input logic a);
        vec_t r;
        r.rst = rst; r.pre_n = pre_n; r.pre = pre; r.din = din;
        r.v = v; r.d = d; r.c = c; r.a = a;
        tbl.push_back(r);
    endtask

    initial begin
        // Lock acquisition after 3 stray bits, then two data bytes
        add(1, 3, 8'h02, 8'hBC, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 1);
        add(0, 0, 8'h00, 8'h55, 1, 8'h55, 0, 1);
        add(0, 0, 8'h00, 8'hA3, 1, 8'hA3, 0, 1);
        // Idles while locked
        add(0, 0, 8'h00, 8'h01, 1, 8'h01, 0, 1);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h01, 1, 1);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h01, 1, 1);
        add(0, 0, 8'h00, 8'h02, 1, 8'h02, 0, 1);
        // Reset while locked, then a broken comma run and relock
        add(1, 0, 8'h00, 8'hBC, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'h12, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 1);
        add(0, 0, 8'h00, 8'h7E, 1, 8'h7E, 0, 1);
        // Stream offset by 5 bits
        add(1, 5, 8'h1A, 8'hBC, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'hBC, 0, 8'h00, 1, 1);
        add(0, 0, 8'h00, 8'hC3, 1, 8'hC3, 0, 1);

        reset_L = 1'b0;
        repeat (2) @(negedge clk_32f);
        reset_L = 1'b1;

        foreach (tbl[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            if (tbl[k].rst) do_reset(tag);
            for (int i = tbl[k].pre_n - 1; i >= 0; i--) send_bit(tbl[k].pre[i], 1'b0);
            send_byte(tbl[k].din, 1'b0);
            chk({tag, " valid"}, {7'd0, valid4}, {7'd0, tbl[k].v});
            chk({tag, " data_out"}, data_out4, tbl[k].d);
            chk({tag, " comma_det"}, {7'd0, comma4}, {7'd0, tbl[k].c});
            chk({tag, " active"}, {7'd0, active4}, {7'd0, tbl[k].a});
        end

        send_bit(1'b0, 1'b0);
        chk("valid count", 8'(vtimes.size()), 8'd6);
        if (vtimes.size() >= 2) chk("valid spacing", 8'(vtimes[1] - vtimes[0]), 8'd8);
        chk("valid/comma overlap", 8'(overlaps), 8'd0);

        // Single-comma lock build
        do_reset("bc1");
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hBC >> i), 1'b1);
        chk("bc1 active early", {7'd0, active1}, 8'h00);
        send_bit(1'b0, 1'b1);
        chk("bc1 active", {7'd0, active1}, 8'h01);
        chk("bc1 comma_det", {7'd0, comma1}, 8'h00);
        send_byte(8'h3C, 1'b1);
        chk("bc1 valid", {7'd0, valid1}, 8'h01);
        chk("bc1 data_out", data_out1, 8'h3C);
        send_bit(1'b0, 1'b1);
        chk("bc1 valid one cycle", {7'd0, valid1}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
